// File: rtl/i2s_rx_capture_pkg.sv
// Shared constants and FSM encoding for the I2S receive capture block.
package i2s_rx_capture_pkg;

   localparam int   I2S_DATA_W = 24;
   localparam int   I2S_SLOT_W = 32;
   localparam logic LR_LEFT    = 1'b0;

   typedef enum logic [1:0] {
      ST_SEEK  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_RIGHT = 2'd2
   } state_t;

endpackage

// File: rtl/i2s_rx_capture_if.sv
// Stereo frame port. Handshake: the producer raises rx_valid with a stable frame;
// the frame transfers on any clk edge where rx_valid & rx_ready are both high.
interface i2s_rx_capture_if #(
   parameter int DATA_W = 24
) ();

   logic              rx_valid;
   logic              rx_ready;
   logic [DATA_W-1:0] rx_left;
   logic [DATA_W-1:0] rx_right;

   modport master (output rx_valid, output rx_left, output rx_right, input rx_ready);
   modport slave  (input rx_valid, input rx_left, input rx_right, output rx_ready);

endinterface

// File: rtl/i2s_rx_capture_pin_sync.sv
// Synchronises bclk/lrclk/sdata through one shared chain and flags the bclk rising edge.
module i2s_rx_capture_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic bclk,
   input  logic lrclk,
   input  logic sdata,
   output logic bit_tick,
   output logic lr_s,
   output logic sd_s
);

   // bit 2 = bclk, bit 1 = lrclk, bit 0 = sdata; one chain keeps the three aligned
   logic [SYNC_STAGES-1:0][2:0] chain;
   logic                        bclk_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain     <= '0;
         bclk_prev <= 1'b0;
         bit_tick  <= 1'b0;
         lr_s      <= 1'b0;
         sd_s      <= 1'b0;
      end else begin
         chain[0] <= {bclk, lrclk, sdata};
         for (int i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
         end
         bclk_prev <= chain[SYNC_STAGES-1][2];
         bit_tick  <= chain[SYNC_STAGES-1][2] & ~bclk_prev;
         lr_s      <= chain[SYNC_STAGES-1][1];
         sd_s      <= chain[SYNC_STAGES-1][0];
      end
   end

endmodule

// File: rtl/i2s_rx_capture.sv
// I2S receive capture: deserialises 24-bit L/R words from the codec ADC and
// presents completed stereo frames on a valid/ready port with sticky error flags.
module i2s_rx_capture
   import i2s_rx_capture_pkg::*;
#(
   parameter int DATA_W      = I2S_DATA_W,
   parameter int SLOT_W      = I2S_SLOT_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    bclk,
   input  logic                    lrclk,
   input  logic                    sdata,
   i2s_rx_capture_if.master        rx,
   output logic [15:0]             frame_count,
   output logic                    overrun,
   output logic                    frame_err,
   input  logic                    clr_err,
   output state_t                  fsm_state
);

   localparam int                 CNT_W    = $clog2(SLOT_W + 1);
   localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]   CNT_DATA = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0]   CNT_SLOT = CNT_W'(SLOT_W);

   logic              bit_tick;
   logic              lr_s;
   logic              sd_s;
   logic              lr_prev;
   logic              lr_chg;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_q;
   logic [DATA_W-1:0] shift_in;
   logic [DATA_W-1:0] left_word;
   logic              word_full;
   state_t            state_q;
   state_t            state_d;
   logic              latch_left;
   logic              commit;
   logic              new_err;
   logic              valid_q;
   logic [DATA_W-1:0] left_q;
   logic [DATA_W-1:0] right_q;

   i2s_rx_capture_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pin_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .bclk     (bclk),
      .lrclk    (lrclk),
      .sdata    (sdata),
      .bit_tick (bit_tick),
      .lr_s     (lr_s),
      .sd_s     (sd_s)
   );

   assign lr_chg    = (lr_s != lr_prev);
   assign shift_in  = {shift_q[DATA_W-2:0], sd_s};
   assign word_full = (bit_cnt >= CNT_DATA);

   assign rx.rx_valid = valid_q;
   assign rx.rx_left  = left_q;
   assign rx.rx_right = right_q;
   assign fsm_state   = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_SEEK;
      end else begin
         state_q <= state_d;
      end
   end

   // A slot boundary is only legal once the outgoing word has all DATA_W bits.
   always_comb begin
      state_d    = state_q;
      latch_left = 1'b0;
      commit     = 1'b0;
      new_err    = 1'b0;
      if (!en) begin
         state_d = ST_SEEK;
      end else if (bit_tick) begin
         case (state_q)
            ST_SEEK: begin
               if (lr_chg && (lr_s == LR_LEFT)) state_d = ST_LEFT;
            end
            ST_LEFT: begin
               if (lr_chg) begin
                  if (word_full) begin
                     state_d    = ST_RIGHT;
                     latch_left = 1'b1;
                  end else begin
                     state_d = ST_SEEK;
                     new_err = 1'b1;
                  end
               end
            end
            ST_RIGHT: begin
               if (lr_chg) begin
                  if (word_full) begin
                     state_d = ST_LEFT;
                  end else begin
                     state_d = ST_SEEK;
                     new_err = 1'b1;
                  end
               end else if (bit_cnt == CNT_LAST) begin
                  commit = 1'b1;
               end
            end
            default: state_d = ST_SEEK;
         endcase
      end
   end

   // The lr_chg tick is the I2S delay slot: it restarts the count and shifts nothing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lr_prev <= 1'b0;
         bit_cnt <= '0;
         shift_q <= '0;
      end else if (bit_tick) begin
         lr_prev <= lr_s;
         if (lr_chg) begin
            bit_cnt <= '0;
         end else begin
            if (bit_cnt < CNT_SLOT) bit_cnt <= bit_cnt + CNT_ONE;
            if (bit_cnt < CNT_DATA) shift_q <= shift_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_word   <= '0;
         valid_q     <= 1'b0;
         left_q      <= '0;
         right_q     <= '0;
         frame_count <= '0;
         overrun     <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         if (latch_left) left_word <= shift_q;
         if (commit) begin
            valid_q     <= 1'b1;
            left_q      <= left_word;
            right_q     <= shift_in;
            frame_count <= frame_count + 16'd1;
         end else if (valid_q && rx.rx_ready) begin
            valid_q <= 1'b0;
         end
         // a same-cycle accept frees the register, so that commit is not an overrun
         overrun   <= (overrun & ~clr_err) | (commit & valid_q & ~rx.rx_ready);
         frame_err <= (frame_err & ~clr_err) | new_err;
      end
   end

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Bench for i2s_rx_capture: codec bit-stream model, frame scoreboard, flag and reset checks.
module tb_i2s_rx_capture;
   import i2s_rx_capture_pkg::*;

   localparam int DW = 24;
   localparam int SW = 32;
   localparam int SS = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        bclk = 1'b0;
   logic        lrclk = 1'b0;
   logic        sdata = 1'b0;
   logic        clr_err = 1'b0;
   logic [15:0] frame_count;
   logic        overrun;
   logic        frame_err;
   state_t      fsm_state;

   i2s_rx_capture_if #(.DATA_W(DW)) rx_if ();

   i2s_rx_capture #(
      .DATA_W      (DW),
      .SLOT_W      (SW),
      .SYNC_STAGES (SS)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .bclk        (bclk),
      .lrclk       (lrclk),
      .sdata       (sdata),
      .rx          (rx_if.master),
      .frame_count (frame_count),
      .overrun     (overrun),
      .frame_err   (frame_err),
      .clr_err     (clr_err),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   int             checks = 0;
   int             failures = 0;
   int             bclk_half = 162;
   int             exp_count = 0;
   logic [2*DW-1:0] exp_q[$];

   typedef struct {
      logic [DW-1:0] l;
      logic [DW-1:0] r;
      logic [DW-1:0] exp_l;
      logic [DW-1:0] exp_r;
   } vec_t;
   vec_t vecs[6];

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic logic slot_bit(input logic [DW-1:0] w, input int k);
      if (k >= 1 && k <= DW) return w[DW-k];
      return 1'b0;
   endfunction

   // lrclk and sdata change on the bclk falling edge, as an I2S codec drives them
   task automatic bclk_cycle(input logic lr, input logic sd);
      bclk = 1'b0;
      lrclk = lr;
      sdata = sd;
      #(bclk_half);
      bclk = 1'b1;
      #(bclk_half);
   endtask

   task automatic drive_slot(input logic lr, input logic [DW-1:0] w, input int first, input int last);
      for (int k = first; k < last; k++) bclk_cycle(lr, slot_bit(w, k));
   endtask

   task automatic drive_frame(input logic [DW-1:0] l, input logic [DW-1:0] r, input int left_bits);
      drive_slot(1'b0, l, 0, left_bits);
      drive_slot(1'b1, r, 0, SW);
   endtask

   task automatic ctrl_sync();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      ctrl_sync();
      clr_err = 1'b1;
      ctrl_sync();
      clr_err = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
      check("scoreboard_drain", 48'(exp_q.size()), 48'd0);
   endtask

   // Scoreboard: every accepted frame must match the oldest expectation,
   // and rx_valid must be low the cycle after an accept.
   initial begin
      logic pending;
      logic [2*DW-1:0] e;
      pending = 1'b0;
      forever begin
         @(negedge clk);
         if (pending) begin
            check("valid_one_clk", 48'(rx_if.rx_valid), 48'd0);
            pending = 1'b0;
         end
         if (rx_if.rx_valid && rx_if.rx_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame", {rx_if.rx_left, rx_if.rx_right}, 48'hx);
            end else begin
               e = exp_q.pop_front();
               check("frame_lr", {rx_if.rx_left, rx_if.rx_right}, e);
            end
            pending = 1'b1;
         end
      end
   end

   initial begin
      #(1_000_000);
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] a_l;
      logic [DW-1:0] a_r;
      logic [DW-1:0] tl;
      logic [DW-1:0] tr;

      vecs[0] = '{24'h800000, 24'h7FFFFF, 24'h800000, 24'h7FFFFF};
      vecs[1] = '{24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
      vecs[2] = '{24'hFFFFFF, 24'h000001, 24'hFFFFFF, 24'h000001};
      vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A};
      tl = DW'($urandom_range(0, 24'hFFFFFF));
      tr = DW'($urandom_range(0, 24'hFFFFFF));
      vecs[4] = '{tl, tr, tl, tr};
      tl = DW'($urandom_range(0, 24'hFFFFFF));
      tr = DW'($urandom_range(0, 24'hFFFFFF));
      vecs[5] = '{tl, tr, tl, tr};

      rx_if.rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", 48'(rx_if.rx_valid), 48'd0);
      check("rst_left", 48'(rx_if.rx_left), 48'd0);
      check("rst_right", 48'(rx_if.rx_right), 48'd0);
      check("rst_count", 48'(frame_count), 48'd0);
      check("rst_overrun", 48'(overrun), 48'd0);
      check("rst_frame_err", 48'(frame_err), 48'd0);
      check("rst_state", 48'(fsm_state), 48'(ST_SEEK));
      ctrl_sync();
      rst_n = 1'b1;
      en = 1'b1;
      rx_if.rx_ready = 1'b1;

      // basic capture at roughly 3.072 MHz bclk
      drive_slot(1'b1, '0, 0, SW);
      exp_q.push_back({24'h123456, 24'hABCDEF});
      exp_count++;
      drive_frame(24'h123456, 24'hABCDEF, SW);
      check("t1_count", 48'(frame_count), 48'd1);

      // table of frames, rx_ready held high
      bclk_half = 50;
      ctrl_sync();
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back({vecs[i].exp_l, vecs[i].exp_r});
         exp_count++;
         drive_frame(vecs[i].l, vecs[i].r, SW);
      end
      check("tbl_count", 48'(frame_count), 48'(exp_count));
      check("tbl_overrun", 48'(overrun), 48'd0);

      // ten frames with rx_ready low: overwrite and sticky overrun
      ctrl_sync();
      rx_if.rx_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         exp_count++;
         drive_frame(DW'(32'h100000 + i), DW'(32'hA00000 + i), SW);
         if (i == 1) check("ovr_after_1", 48'(overrun), 48'd0);
         if (i == 2) check("ovr_after_2", 48'(overrun), 48'd1);
      end
      check("ovr_valid", 48'(rx_if.rx_valid), 48'd1);
      check("ovr_held", {rx_if.rx_left, rx_if.rx_right}, {24'h10000A, 24'hA0000A});
      check("ovr_count", 48'(frame_count), 48'(exp_count));
      pulse_clr();
      check("ovr_cleared", 48'(overrun), 48'd0);
      exp_q.push_back({24'h10000A, 24'hA0000A});
      ctrl_sync();
      rx_if.rx_ready = 1'b1;
      wait_drain();

      // short left slot
      ctrl_sync();
      drive_frame(24'h0F0F0F, 24'hF0F0F0, 16);
      check("short_err", 48'(frame_err), 48'd1);
      check("short_state", 48'(fsm_state), 48'(ST_SEEK));
      check("short_count", 48'(frame_count), 48'(exp_count));
      exp_q.push_back({24'h654321, 24'h13579B});
      exp_count++;
      drive_frame(24'h654321, 24'h13579B, SW);
      check("short_recover", 48'(frame_count), 48'(exp_count));
      pulse_clr();
      check("err_cleared", 48'(frame_err), 48'd0);

      // en dropped mid-left: partial frame lost, held frame untouched
      a_l = 24'h2468AC;
      a_r = 24'hFDB975;
      ctrl_sync();
      rx_if.rx_ready = 1'b0;
      exp_count++;
      drive_frame(a_l, a_r, SW);
      drive_slot(1'b0, 24'h111111, 0, 10);
      en = 1'b0;
      drive_slot(1'b0, 24'h111111, 10, SW);
      drive_slot(1'b1, 24'h222222, 0, SW);
      ctrl_sync();
      en = 1'b1;
      repeat (4) @(negedge clk);
      check("en_valid", 48'(rx_if.rx_valid), 48'd1);
      check("en_held", {rx_if.rx_left, rx_if.rx_right}, {a_l, a_r});
      check("en_count", 48'(frame_count), 48'(exp_count));
      check("en_state", 48'(fsm_state), 48'(ST_SEEK));
      exp_q.push_back({a_l, a_r});
      ctrl_sync();
      rx_if.rx_ready = 1'b1;
      wait_drain();
      exp_q.push_back({24'h0C0FFE, 24'hBEEF00});
      exp_count++;
      ctrl_sync();
      drive_frame(24'h0C0FFE, 24'hBEEF00, SW);
      check("en_resume_count", 48'(frame_count), 48'(exp_count));
      check("flags_clean", {overrun, frame_err}, 48'd0);

      // reset asserted at right bit 12 of frame 3
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({DW'(32'h300000 + i), DW'(32'h400000 + i)});
         drive_frame(DW'(32'h300000 + i), DW'(32'h400000 + i), SW);
      end
      wait_drain();
      drive_slot(1'b0, 24'h777777, 0, SW);
      drive_slot(1'b1, 24'h888888, 0, 13);
      rst_n = 1'b0;
      #2;
      check("arst_valid", 48'(rx_if.rx_valid), 48'd0);
      check("arst_lr", {rx_if.rx_left, rx_if.rx_right}, 48'd0);
      check("arst_count", 48'(frame_count), 48'd0);
      check("arst_flags", {overrun, frame_err}, 48'd0);
      check("arst_state", 48'(fsm_state), 48'(ST_SEEK));
      ctrl_sync();
      rst_n = 1'b1;
      drive_slot(1'b1, 24'h888888, 13, SW);
      check("arst_no_commit", 48'(frame_count), 48'd0);
      exp_q.push_back({24'h5A0001, 24'hA50002});
      drive_frame(24'h5A0001, 24'hA50002, SW);
      check("arst_first", 48'(frame_count), 48'd1);

      wait_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
